// File: rtl/match_sequencer.sv
// Game-flow controller for the fencing display: menu, countdown, play, pause,
// point hold and game over, driven by IR commands, frame ticks and hit pulses.
module match_sequencer #(
    parameter logic [31:0] IR_START       = 32'h20DF_5BA4,
    parameter logic [31:0] IR_START_ALT   = 32'h20DF_5AA5,
    parameter logic [31:0] IR_PAUSE       = 32'h20DF_10EF,
    parameter logic [31:0] IR_RESET       = 32'h20DF_8D72,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned COUNT_SECS     = 3,
    parameter int unsigned POINT_FRAMES   = 120,
    parameter int unsigned WIN_SCORE      = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] ir_in,
    input  logic        ir_valid_in,
    input  logic        nf_in,
    input  logic        player_hit_in,
    input  logic        opponent_hit_in,
    output logic [2:0]  state_out,
    output logic        display_start_out,
    output logic        play_active_out,
    output logic [3:0]  countdown_out,
    output logic [3:0]  player_score_out,
    output logic [3:0]  opponent_score_out,
    output logic [1:0]  point_winner_out,
    output logic        game_over_out,
    output logic        match_winner_out
);

    localparam logic [2:0] ST_MENU      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_POINT     = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    localparam logic [7:0] FRAME_RELOAD = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] POINT_RELOAD = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] SECS_RELOAD  = 4'(COUNT_SECS);
    localparam logic [3:0] WIN          = 4'(WIN_SCORE);

    logic [2:0] state_q, state_d;
    logic [7:0] frames_q, frames_d;
    logic [3:0] secs_q, secs_d;
    logic [3:0] p_score_q, p_score_d;
    logic [3:0] o_score_q, o_score_d;
    logic [1:0] winner_q, winner_d;
    logic       match_winner_q, match_winner_d;
    logic       display_start_q, display_start_d;
    logic       play_active_q, play_active_d;
    logic       game_over_q, game_over_d;
    logic [3:0] countdown_q, countdown_d;

    logic cmd_start, cmd_pause, cmd_reset;

    assign cmd_start = ir_valid_in && ((ir_in == IR_START) || (ir_in == IR_START_ALT));
    assign cmd_pause = ir_valid_in && (ir_in == IR_PAUSE);
    assign cmd_reset = ir_valid_in && (ir_in == IR_RESET);

    always_comb begin
        state_d         = state_q;
        frames_d        = frames_q;
        secs_d          = secs_q;
        p_score_d       = p_score_q;
        o_score_d       = o_score_q;
        winner_d        = winner_q;
        match_winner_d  = match_winner_q;
        display_start_d = display_start_q;

        if (cmd_reset) begin
            state_d         = ST_MENU;
            p_score_d       = '0;
            o_score_d       = '0;
            winner_d        = 2'b00;
            frames_d        = '0;
            secs_d          = '0;
            display_start_d = 1'b1;
        end else begin
            case (state_q)
                ST_MENU: begin
                    if (cmd_start) begin
                        state_d         = ST_COUNTDOWN;
                        p_score_d       = '0;
                        o_score_d       = '0;
                        secs_d          = SECS_RELOAD;
                        frames_d        = FRAME_RELOAD;
                        display_start_d = 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (nf_in) begin
                        if (frames_q != '0) begin
                            frames_d = frames_q - 8'd1;
                        end else if (secs_q == 4'd1) begin
                            state_d = ST_PLAY;
                        end else begin
                            secs_d   = secs_q - 4'd1;
                            frames_d = FRAME_RELOAD;
                        end
                    end
                end
                ST_PLAY: begin
                    // Pause outranks hits, so a same-cycle hit is simply dropped.
                    if (cmd_pause) begin
                        state_d = ST_PAUSE;
                    end else if (player_hit_in || opponent_hit_in) begin
                        state_d  = ST_POINT;
                        frames_d = POINT_RELOAD;
                        if (player_hit_in && opponent_hit_in) begin
                            winner_d = 2'b11;
                        end else if (player_hit_in) begin
                            winner_d = 2'b01;
                            if (p_score_q < WIN) p_score_d = p_score_q + 4'd1;
                        end else begin
                            winner_d = 2'b10;
                            if (o_score_q < WIN) o_score_d = o_score_q + 4'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cmd_pause || cmd_start) begin
                        state_d  = ST_COUNTDOWN;
                        secs_d   = SECS_RELOAD;
                        frames_d = FRAME_RELOAD;
                    end
                end
                ST_POINT: begin
                    if (nf_in) begin
                        if (frames_q != '0) begin
                            frames_d = frames_q - 8'd1;
                        end else if ((p_score_q == WIN) || (o_score_q == WIN)) begin
                            state_d        = ST_GAME_OVER;
                            match_winner_d = (o_score_q == WIN);
                        end else begin
                            state_d  = ST_COUNTDOWN;
                            secs_d   = SECS_RELOAD;
                            frames_d = FRAME_RELOAD;
                            winner_d = 2'b00;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (cmd_start) begin
                        state_d         = ST_MENU;
                        p_score_d       = '0;
                        o_score_d       = '0;
                        display_start_d = 1'b1;
                    end
                end
                default: state_d = ST_MENU;
            endcase
        end

        // State-decoded outputs come from the next state so they flop alongside it.
        play_active_d = (state_d == ST_PLAY);
        game_over_d   = (state_d == ST_GAME_OVER);
        countdown_d   = (state_d == ST_COUNTDOWN) ? secs_d : 4'd0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= ST_MENU;
            frames_q        <= '0;
            secs_q          <= '0;
            p_score_q       <= '0;
            o_score_q       <= '0;
            winner_q        <= 2'b00;
            match_winner_q  <= 1'b0;
            display_start_q <= 1'b1;
            play_active_q   <= 1'b0;
            game_over_q     <= 1'b0;
            countdown_q     <= '0;
        end else begin
            state_q         <= state_d;
            frames_q        <= frames_d;
            secs_q          <= secs_d;
            p_score_q       <= p_score_d;
            o_score_q       <= o_score_d;
            winner_q        <= winner_d;
            match_winner_q  <= match_winner_d;
            display_start_q <= display_start_d;
            play_active_q   <= play_active_d;
            game_over_q     <= game_over_d;
            countdown_q     <= countdown_d;
        end
    end

    assign state_out          = state_q;
    assign display_start_out  = display_start_q;
    assign play_active_out    = play_active_q;
    assign countdown_out      = countdown_q;
    assign player_score_out   = p_score_q;
    assign opponent_score_out = o_score_q;
    assign point_winner_out   = winner_q;
    assign game_over_out      = game_over_q;
    assign match_winner_out   = match_winner_q;

endmodule
